// File: rtl/hid_pkg.sv
// Shared HID key definitions and the key-tracker state encoding used by
// the report consumer and any block that decodes its keycodes.
package hid_pkg;

  localparam logic [7:0] KEY_NONE         = 8'h00;
  localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_W = 8'h1A;

  localparam int NUM_SLOTS = 3;

  typedef enum logic [1:0] {
    RECV   = 2'd0,
    PRUNE  = 2'd1,
    APPEND = 2'd2,
    COMMIT = 2'd3
  } tracker_state_t;

endpackage

// File: rtl/hid_key_tracker.sv
// Consumes byte-serial HID boot-keyboard reports and presents up to three
// held keys ordered oldest (keycode0) to newest (keycode2).
//
// Handshake: a byte transfers on a rising Clk edge when rpt_valid && rpt_ready;
// rpt_ready depends only on state (high in RECV), never on rpt_valid.
module hid_key_tracker
  import hid_pkg::*;
#(
  parameter int RPT_BYTES = 8,
  parameter int NUM_KEYS  = RPT_BYTES - 2
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [7:0]     rpt_byte,
  input  logic           rpt_valid,
  output logic           rpt_ready,
  output logic [7:0]     keycode0,
  output logic [7:0]     keycode1,
  output logic [7:0]     keycode2,
  output logic [7:0]     modifiers,
  output logic           report_done,
  output logic           rollover_err,
  output tracker_state_t dbg_state
);

  localparam int IW = $clog2(RPT_BYTES);
  localparam int KW = $clog2(NUM_KEYS);
  localparam logic [IW-1:0] LAST_IDX = IW'(RPT_BYTES - 1);
  localparam logic [KW-1:0] LAST_K   = KW'(NUM_KEYS - 1);

  tracker_state_t state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [KW-1:0]  k_q, k_d;
  logic [7:0]     key_buf_q [NUM_KEYS];
  logic [7:0]     key_buf_d [NUM_KEYS];
  logic [7:0]     mod_buf_q, mod_buf_d;
  logic [7:0]     slot_q [NUM_SLOTS];
  logic [7:0]     slot_d [NUM_SLOTS];
  logic [7:0]     kc_q [NUM_SLOTS];
  logic [7:0]     kc_d [NUM_SLOTS];
  logic [7:0]     mod_q, mod_d;
  logic           done_q, done_d;
  logic           roll_q, roll_d;
  logic           roll_pend_q, roll_pend_d;

  logic [7:0]     pruned [NUM_SLOTS];
  logic [7:0]     appended [NUM_SLOTS];
  logic           all_roll;
  logic           key_held;
  logic [7:0]     key_cur;

  assign key_cur = key_buf_q[k_q];

  always_comb begin
    all_roll = 1'b1;
    for (int j = 0; j < NUM_KEYS; j++) begin
      if (key_buf_q[j] != KEY_ERR_ROLLOVER) all_roll = 1'b0;
    end
  end

  // Keep slots whose key is still reported, packed toward slot 0 in order.
  always_comb begin
    int unsigned n;
    logic present;
    n = 0;
    for (int i = 0; i < NUM_SLOTS; i++) pruned[i] = KEY_NONE;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      present = 1'b0;
      for (int j = 0; j < NUM_KEYS; j++) begin
        if (key_buf_q[j] == slot_q[i]) present = 1'b1;
      end
      if (slot_q[i] != KEY_NONE && present) begin
        pruned[n] = slot_q[i];
        n = n + 1;
      end
    end
  end

  // Slots are compact, so the first empty slot is the append position and
  // a full last slot means no room; in that case appended equals slot_q.
  always_comb begin
    logic placed;
    placed   = 1'b0;
    key_held = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      appended[i] = slot_q[i];
      if (slot_q[i] == key_cur) key_held = 1'b1;
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!placed && slot_q[i] == KEY_NONE) begin
        appended[i] = key_cur;
        placed      = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    k_d         = k_q;
    key_buf_d   = key_buf_q;
    mod_buf_d   = mod_buf_q;
    slot_d      = slot_q;
    kc_d        = kc_q;
    mod_d       = mod_q;
    done_d      = 1'b0;
    roll_d      = roll_q;
    roll_pend_d = roll_pend_q;

    case (state_q)
      RECV: begin
        if (rpt_valid) begin
          if (idx_q == '0) mod_buf_d = rpt_byte;
          else if (idx_q >= IW'(2)) key_buf_d[idx_q - IW'(2)] = rpt_byte;
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) state_d = PRUNE;
        end
      end
      PRUNE: begin
        if (all_roll) begin
          roll_pend_d = 1'b1;
          state_d     = COMMIT;
        end else begin
          roll_pend_d = 1'b0;
          slot_d      = pruned;
          k_d         = '0;
          state_d     = APPEND;
        end
      end
      APPEND: begin
        if (key_cur != KEY_NONE && !key_held) slot_d = appended;
        if (k_q == LAST_K) state_d = COMMIT;
        else k_d = k_q + KW'(1);
      end
      COMMIT: begin
        done_d = 1'b1;
        if (roll_pend_q) begin
          roll_d = 1'b1;
        end else begin
          kc_d   = slot_q;
          mod_d  = mod_buf_q;
          roll_d = 1'b0;
        end
        state_d = RECV;
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= RECV;
      idx_q       <= '0;
      k_q         <= '0;
      mod_buf_q   <= '0;
      mod_q       <= '0;
      done_q      <= 1'b0;
      roll_q      <= 1'b0;
      roll_pend_q <= 1'b0;
      for (int j = 0; j < NUM_KEYS; j++) key_buf_q[j] <= KEY_NONE;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= KEY_NONE;
        kc_q[i]   <= KEY_NONE;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      key_buf_q   <= key_buf_d;
      mod_buf_q   <= mod_buf_d;
      slot_q      <= slot_d;
      kc_q        <= kc_d;
      mod_q       <= mod_d;
      done_q      <= done_d;
      roll_q      <= roll_d;
      roll_pend_q <= roll_pend_d;
    end
  end

  assign rpt_ready    = (state_q == RECV);
  assign keycode0     = kc_q[0];
  assign keycode1     = kc_q[1];
  assign keycode2     = kc_q[2];
  assign modifiers    = mod_q;
  assign report_done  = done_q;
  assign rollover_err = roll_q;
  assign dbg_state    = state_q;

endmodule
